// File: rtl/memory_unit_if.sv
// CPU request/response bus and loader handshake for memory_unit.
// master = CPU / loader side, slave = the RAM.
interface memory_unit_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH+DATA_WIDTH:0] memory_in;
   logic [DATA_WIDTH-1:0]          memory_out;
   logic                           ready;
   logic                           load_valid;
   logic                           load_ready;
   logic [ADDR_WIDTH-1:0]          load_addr;
   logic [DATA_WIDTH-1:0]          load_data;

   modport master (
      output memory_in,
      output load_valid,
      output load_addr,
      output load_data,
      input  memory_out,
      input  ready,
      input  load_ready
   );

   modport slave (
      input  memory_in,
      input  load_valid,
      input  load_addr,
      input  load_data,
      output memory_out,
      output ready,
      output load_ready
   );
endinterface

// File: rtl/memory_unit.sv
// Byte-wide synchronous RAM with CPU request bus, loader port
// and a reset-time clear sequencer.
module memory_unit #(
   parameter int ADDR_WIDTH     = 6,
   parameter int DATA_WIDTH     = 8,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic          clk,
   input  logic          rst,
   memory_unit_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int WE    = ADDR_WIDTH + DATA_WIDTH;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] clear_cnt;
   logic [DATA_WIDTH-1:0] memory_out;
   logic                  ready;

   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  cpu_wr;
   logic                  ld_wr;
   logic                  wr_en;
   logic                  load_ready;

   assign rd_addr    = bus.memory_in[WE-1:DATA_WIDTH];
   assign cpu_wr     = ready & bus.memory_in[WE];
   // CPU write has priority; the loader simply stalls that cycle
   assign load_ready = ready & ~bus.memory_in[WE];
   assign ld_wr      = bus.load_valid & load_ready;
   assign wr_en      = cpu_wr | ld_wr;
   assign wr_addr    = cpu_wr ? rd_addr : bus.load_addr;
   assign wr_data    = cpu_wr ? bus.memory_in[DATA_WIDTH-1:0]
                              : bus.load_data;

   assign bus.memory_out = memory_out;
   assign bus.ready      = ready;
   assign bus.load_ready = load_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
         ready      <= 1'b0;
         clear_cnt  <= '0;
         memory_out <= '0;
      end else begin
         unique case (state)
            CLEAR: begin
               mem[clear_cnt] <= '0;
               clear_cnt      <= clear_cnt + 1'b1;
               memory_out     <= '0;
               if (clear_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               ready <= 1'b1;
               if (wr_en)
                  mem[wr_addr] <= wr_data;
               // write-first: a same-edge write to the read address is forwarded
               if (!ready)
                  memory_out <= '0;
               else if (wr_en && wr_addr == rd_addr)
                  memory_out <= wr_data;
               else
                  memory_out <= mem[rd_addr];
            end
         endcase
      end
   end
endmodule

// File: tb/tb_memory_unit.sv
// Directed self-checking bench for memory_unit, covering both
// the clearing and the non-clearing reset variants.
module tb_memory_unit;
   logic clk = 1'b0;
   logic rst;
   logic rst_nc;
   int   errors = 0;
   int   checks = 0;

   memory_unit_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bus ();
   memory_unit_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bus_nc ();

   memory_unit #(.CLEAR_ON_RESET(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   memory_unit #(.CLEAR_ON_RESET(0)) dut_nc (
      .clk (clk),
      .rst (rst_nc),
      .bus (bus_nc)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [7:0] got,
                        input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cpu(input logic we, input logic [5:0] a,
                      input logic [7:0] d);
      bus.memory_in = {we, a, d};
   endtask

   task automatic expect_clear(input string tag);
      for (int i = 1; i <= 64; i++) begin
         tick();
         check(tag, {7'd0, bus.ready}, (i == 64) ? 8'd1 : 8'd0);
         check(tag, bus.memory_out, 8'h00);
      end
   endtask

   initial begin
      rst = 1'b1;
      rst_nc = 1'b1;
      bus.memory_in = '0;
      bus.load_valid = 1'b0;
      bus.load_addr = '0;
      bus.load_data = '0;
      bus_nc.memory_in = '0;
      bus_nc.load_valid = 1'b0;
      bus_nc.load_addr = '0;
      bus_nc.load_data = '0;
      tick();
      tick();
      check("rst_ready", {7'd0, bus.ready}, 8'd0);
      check("rst_out", bus.memory_out, 8'h00);
      check("rst_lrdy", {7'd0, bus.load_ready}, 8'd0);

      rst = 1'b0;
      rst_nc = 1'b0;
      expect_clear("clear");

      for (int a = 0; a < 64; a++) begin
         cpu(1'b0, 6'(a), 8'h00);
         tick();
         check("read0", bus.memory_out, 8'h00);
      end

      // loader preload
      cpu(1'b0, 6'h00, 8'h00);
      bus.load_valid = 1'b1;
      bus.load_addr = 6'h05;
      bus.load_data = 8'hA7;
      #1;
      check("ld_ready", {7'd0, bus.load_ready}, 8'd1);
      tick();
      bus.load_valid = 1'b0;
      cpu(1'b0, 6'h05, 8'h00);
      tick();
      check("ld_read", bus.memory_out, 8'hA7);

      // contention: CPU write wins, loader stalls
      bus.load_valid = 1'b1;
      bus.load_addr = 6'h10;
      bus.load_data = 8'h33;
      cpu(1'b1, 6'h10, 8'h5C);
      #1;
      check("cont_lrdy0", {7'd0, bus.load_ready}, 8'd0);
      tick();
      check("cont_cpu", bus.memory_out, 8'h5C);
      cpu(1'b0, 6'h10, 8'h00);
      #1;
      check("cont_lrdy1", {7'd0, bus.load_ready}, 8'd1);
      tick();
      check("cont_fwd", bus.memory_out, 8'h33);
      bus.load_valid = 1'b0;
      tick();
      check("cont_read", bus.memory_out, 8'h33);

      // write-first forwarding
      cpu(1'b1, 6'h3F, 8'h99);
      tick();
      check("wf_cpu", bus.memory_out, 8'h99);
      cpu(1'b0, 6'h21, 8'h00);
      bus.load_valid = 1'b1;
      bus.load_addr = 6'h20;
      bus.load_data = 8'h11;
      tick();
      check("wf_other", bus.memory_out, 8'h00);
      bus.load_valid = 1'b0;
      cpu(1'b0, 6'h20, 8'h00);
      tick();
      check("wf_rd20", bus.memory_out, 8'h11);
      cpu(1'b0, 6'h3F, 8'h00);
      tick();
      check("wf_rd3f", bus.memory_out, 8'h99);

      // reset in the middle of clearing
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 29; i++)
         tick();
      check("mid_ready", {7'd0, bus.ready}, 8'd0);
      rst = 1'b1;
      cpu(1'b1, 6'h01, 8'hEE);
      tick();
      rst = 1'b0;
      cpu(1'b0, 6'h3F, 8'h00);
      check("mid_rst", {7'd0, bus.ready}, 8'd0);
      expect_clear("reclear");
      for (int k = 0; k < 4; k++) begin
         logic [5:0] addrs [4];
         addrs = '{6'h05, 6'h10, 6'h3F, 6'h01};
         cpu(1'b0, addrs[k], 8'h00);
         tick();
         check("reclr_rd", bus.memory_out, 8'h00);
      end

      // non-clearing variant keeps contents across reset
      bus_nc.load_valid = 1'b1;
      bus_nc.load_addr = 6'h07;
      bus_nc.load_data = 8'h42;
      tick();
      bus_nc.load_valid = 1'b0;
      rst_nc = 1'b1;
      tick();
      check("nc_rst", {7'd0, bus_nc.ready}, 8'd0);
      rst_nc = 1'b0;
      tick();
      check("nc_ready", {7'd0, bus_nc.ready}, 8'd1);
      bus_nc.memory_in = {1'b0, 6'h07, 8'h00};
      tick();
      check("nc_read", bus_nc.memory_out, 8'h42);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
